ci_rx_packer: RTL and testbench

//  Receive end of the camera interface: samples VSync/HSync/Data from the camera (ci_if rx side) in the camera Clk domain.

---
 rtl/ci_rx_packer_pkg.sv | 18 +
 rtl/ci_rx_out_queue.sv | 59 +++++
 rtl/ci_rx_packer.sv | 132 +++++++++++++
 tb/tb_ci_rx_packer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ci_rx_packer_pkg.sv
// ci_rx_packer_pkg: shared types, defaults and helpers for the camera receive packer
package ci_rx_packer_pkg;
  localparam int CI_PIXEL_W = 8;
  localparam int CI_PIX_PER_WORD = 4;
  localparam int CI_Q_DEPTH = 4;
  localparam int CI_PAYLOAD_W = CI_PIXEL_W * CI_PIX_PER_WORD;
  localparam int CI_FIFO_W = CI_PAYLOAD_W + 5;
  typedef enum logic [1:0] {TAG_PIX = 2'd0, TAG_FS = 2'd1, TAG_LE = 2'd2, TAG_FE = 2'd3} t_ci_tag;
  typedef struct packed {
    t_ci_tag tag;
    logic [2:0] cnt;
    logic [CI_PAYLOAD_W-1:0] payload;
  } t_ci_word;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_FS = 2'd1, FRAME = 2'd2, LINE = 2'd3} t_ci_rx_state;
  function automatic logic [15:0] satInc(input logic [15:0] v, input logic inc);
    return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction
endpackage

// File: rtl/ci_rx_out_queue.sv
// ci_rx_out_queue: small FIFO with three ordered write ports, one read port and drop-on-full
module ci_rx_out_queue #(
  parameter int DEPTH = 4,
  parameter int W = 37
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [2:0]        wrEn,
  input  logic              wrPrio,
  input  logic [2:0][W-1:0] wrData,
  output logic              drop,
  output logic              rdValid,
  output logic [W-1:0]      rdData,
  input  logic              rdReady
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [PW:0] count;
  logic pop;
  logic [2:0] take;
  int free, acc;
  int slot [3];
  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % DEPTH);
  endfunction
  assign rdValid = count != '0;
  assign rdData = mem[rdPtr];
  assign pop = rdValid & rdReady;
  // The last free slot is held back for a prioritised port-0 entry (frame start)
  always_comb begin
    free = DEPTH - int'(count) + int'(pop);
    acc = 0;
    take = '0;
    drop = 1'b0;
    slot = '{default: 0};
    for (int k = 0; k < 3; k++)
      if (wrEn[k]) begin
        if (acc < free - ((k == 0 && wrPrio) ? 0 : 1)) begin
          take[k] = 1'b1;
          slot[k] = acc;
          acc = acc + 1;
        end else drop = 1'b1;
      end
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int k = 0; k < 3; k++)
        if (take[k]) mem[wrap(int'(wrPtr) + slot[k])] <= wrData[k];
      wrPtr <= wrap(int'(wrPtr) + acc);
      rdPtr <= pop ? wrap(int'(rdPtr) + 1) : rdPtr;
      count <= (PW+1)'(int'(count) + acc - int'(pop));
    end
endmodule

// File: rtl/ci_rx_packer.sv
// ci_rx_packer: samples the camera bus, packs pixels into tagged words and inserts
// frame-start / line-end / frame-end markers for the CSI FIFO.
module ci_rx_packer
  import ci_rx_packer_pkg::*;
#(
  parameter int PIXEL_W = CI_PIXEL_W,
  parameter int PIX_PER_WORD = CI_PIX_PER_WORD,
  parameter int Q_DEPTH = CI_Q_DEPTH,
  parameter int FIFO_W = PIXEL_W * PIX_PER_WORD + 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  output logic              Enable,
  input  logic              VSync,
  input  logic              HSync,
  input  logic [PIXEL_W-1:0] Data,
  output logic [FIFO_W-1:0] DataRx,
  output logic              ValidRx,
  input  logic              FullRx,
  output logic              Overflow,
  output logic [15:0]       FrameCnt
);
  localparam int PW = PIXEL_W * PIX_PER_WORD;
  t_ci_rx_state state, stateNext;
  logic vsR, hsR, vsD, hsD;
  logic [PIXEL_W-1:0] dR;
  logic [PW-1:0] packBuf, mBuf;
  logic [2:0] packCnt, mCnt;
  logic [15:0] pixCnt, pixNext, lineCnt, lineNext;
  logic pixValid, lineEnd, abort, fsPush, lePush, fePush, pixPush, feErr, qDrop;
  logic [2:0] wrEn;
  logic [2:0][FIFO_W-1:0] wrData;
  always_comb begin
    stateNext = state;
    pixValid = 1'b0;
    lineEnd = 1'b0;
    abort = 1'b0;
    fsPush = 1'b0;
    lePush = 1'b0;
    fePush = 1'b0;
    case (state)
      IDLE: stateNext = (Enable & ~vsR) ? WAIT_FS : IDLE;
      WAIT_FS:
        if (~En) stateNext = IDLE;
        else if (vsR & ~vsD) begin
          fsPush = 1'b1;
          stateNext = FRAME;
        end
      FRAME:
        if (~En) begin
          abort = 1'b1;
          fePush = 1'b1;
          stateNext = IDLE;
        end else if (~vsR) begin
          fePush = 1'b1;
          stateNext = WAIT_FS;
        end else if (hsR & ~hsD) begin
          pixValid = 1'b1;
          stateNext = LINE;
        end
      LINE: begin
        pixValid = vsR & hsR;
        if (~En) begin
          abort = 1'b1;
          fePush = 1'b1;
          stateNext = IDLE;
        end else if (~hsR | ~vsR) begin
          lineEnd = 1'b1;
          lePush = 1'b1;
          fePush = ~vsR;
          stateNext = vsR ? FRAME : WAIT_FS;
        end
      end
    endcase
  end
  // Merge the current pixel before deciding on a push so an abort or full word includes it
  always_comb begin
    mBuf = packBuf;
    if (pixValid) mBuf[32'(packCnt) * PIXEL_W +: PIXEL_W] = dR;
    mCnt = packCnt + 3'(pixValid);
    pixPush = (mCnt == 3'(PIX_PER_WORD)) | ((lineEnd | abort) & (mCnt != 3'd0));
    pixNext = satInc(pixCnt, pixValid);
    lineNext = satInc(lineCnt, lePush);
    feErr = Overflow | abort;
    wrEn = {fePush, lePush, pixPush | fsPush};
    wrData[0] = fsPush ? {TAG_FS, 3'd0, PW'(FrameCnt)} : {TAG_PIX, mCnt, mBuf};
    wrData[1] = {TAG_LE, 3'd0, PW'(pixNext)};
    wrData[2] = {TAG_FE, 3'd0, PW'({feErr, lineNext})};
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      Enable <= 1'b0;
      vsR <= 1'b0;
      hsR <= 1'b0;
      vsD <= 1'b0;
      hsD <= 1'b0;
      dR <= '0;
      state <= IDLE;
      packBuf <= '0;
      packCnt <= '0;
      pixCnt <= '0;
      lineCnt <= '0;
      FrameCnt <= '0;
      Overflow <= 1'b0;
    end else begin
      Enable <= En;
      vsR <= VSync;
      hsR <= HSync;
      vsD <= vsR;
      hsD <= hsR;
      dR <= Data;
      state <= stateNext;
      packBuf <= pixPush ? '0 : mBuf;
      packCnt <= pixPush ? 3'd0 : mCnt;
      pixCnt <= (lineEnd | abort) ? 16'd0 : pixNext;
      lineCnt <= fsPush ? 16'd0 : lineNext;
      FrameCnt <= FrameCnt + 16'(fsPush);
      Overflow <= qDrop | (Overflow & ~fsPush);
    end
  ci_rx_out_queue #(.DEPTH(Q_DEPTH), .W(FIFO_W)) uQueue (
    .Clk(Clk),
    .Rst(Rst),
    .wrEn(wrEn),
    .wrPrio(fsPush),
    .wrData(wrData),
    .drop(qDrop),
    .rdValid(ValidRx),
    .rdData(DataRx),
    .rdReady(~FullRx)
  );
endmodule

// File: tb/tb_ci_rx_packer.sv
// tb_ci_rx_packer: directed frames with hand-computed marker and pixel words
module tb_ci_rx_packer;
  import ci_rx_packer_pkg::*;
  logic Clk = 1'b0, Rst, En, VSync, HSync, FullRx;
  logic [7:0] Data;
  logic Enable, ValidRx, Overflow;
  logic [36:0] DataRx;
  logic [15:0] FrameCnt;
  int checks = 0, failures = 0, cyc = 0, p3Cyc = 0, latRef = 0, lastCyc = 0, a = 0, b = 0;
  logic [36:0] rxQ [$];
  int cycQ [$];
  ci_rx_packer dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Enable(Enable), .VSync(VSync), .HSync(HSync), .Data(Data),
    .DataRx(DataRx), .ValidRx(ValidRx), .FullRx(FullRx), .Overflow(Overflow), .FrameCnt(FrameCnt)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk)
    if (ValidRx && !FullRx) begin
      rxQ.push_back(DataRx);
      cycQ.push_back(cyc);
    end
  function automatic logic [36:0] wd(input logic [1:0] t, input logic [2:0] c, input logic [31:0] p);
    return {t, c, p};
  endfunction
  task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask
  task automatic expectWord(input string tag, input logic [36:0] exp);
    logic [36:0] w;
    w = '1;
    lastCyc = 0;
    if (rxQ.size() != 0) begin
      w = rxQ.pop_front();
      lastCyc = cycQ.pop_front();
    end
    checkVal(tag, 64'(w), 64'(exp));
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic doLine(input int n, input logic [7:0] base, input bit endFrame);
    for (int i = 0; i < n; i++) begin
      Data = base + 8'(i);
      HSync = 1'b1;
      if (i == 3) p3Cyc = cyc;
      tick();
    end
    HSync = 1'b0;
    Data = '0;
    if (endFrame) VSync = 1'b0;
    tick();
    tick();
  endtask
  initial begin
    Rst = 1'b1; En = 1'b0; VSync = 1'b0; HSync = 1'b0; Data = '0; FullRx = 1'b0;
    tick();
    tick();
    checkVal("rst.enable", 64'(Enable), 0);
    checkVal("rst.valid", 64'(ValidRx), 0);
    checkVal("rst.data", 64'(DataRx), 0);
    checkVal("rst.ovf", 64'(Overflow), 0);
    checkVal("rst.frameCnt", 64'(FrameCnt), 0);
    Rst = 1'b0;
    En = 1'b1;
    repeat (4) tick();
    checkVal("enable", 64'(Enable), 1);
    // frame A: two 8-pixel lines
    VSync = 1'b1; tick(); tick();
    doLine(8, 8'h10, 1'b0);
    latRef = p3Cyc;
    doLine(8, 8'h20, 1'b0);
    VSync = 1'b0;
    repeat (6) tick();
    expectWord("A.fs", wd(2'd1, 3'd0, 32'h0));
    expectWord("A.p0", wd(2'd0, 3'd4, 32'h13121110));
    checkVal("A.latency", 64'(lastCyc - latRef), 2);
    expectWord("A.p1", wd(2'd0, 3'd4, 32'h17161514));
    expectWord("A.le0", wd(2'd2, 3'd0, 32'd8));
    expectWord("A.p2", wd(2'd0, 3'd4, 32'h23222120));
    expectWord("A.p3", wd(2'd0, 3'd4, 32'h27262524));
    expectWord("A.le1", wd(2'd2, 3'd0, 32'd8));
    expectWord("A.fe", wd(2'd3, 3'd0, 32'd2));
    checkVal("A.frameCnt", 64'(FrameCnt), 1);
    // frame B: partial word, then HSync and VSync fall together
    VSync = 1'b1; tick(); tick();
    doLine(6, 8'h30, 1'b0);
    doLine(5, 8'h40, 1'b1);
    repeat (6) tick();
    expectWord("B.fs", wd(2'd1, 3'd0, 32'd1));
    expectWord("B.p0", wd(2'd0, 3'd4, 32'h33323130));
    expectWord("B.p1", wd(2'd0, 3'd2, 32'h00003534));
    expectWord("B.le0", wd(2'd2, 3'd0, 32'd6));
    expectWord("B.p2", wd(2'd0, 3'd4, 32'h43424140));
    expectWord("B.p3", wd(2'd0, 3'd1, 32'h00000044));
    a = lastCyc;
    expectWord("B.le1", wd(2'd2, 3'd0, 32'd5));
    b = lastCyc;
    expectWord("B.fe", wd(2'd3, 3'd0, 32'd2));
    checkVal("B.gap", {32'(lastCyc - b), 32'(b - a)}, {32'd1, 32'd1});
    // frame C: FIFO full for a whole 16-pixel line
    VSync = 1'b1; tick(); tick();
    repeat (3) tick();
    expectWord("C.fs", wd(2'd1, 3'd0, 32'd2));
    FullRx = 1'b1;
    doLine(16, 8'h50, 1'b0);
    repeat (3) tick();
    checkVal("C.ovf", 64'(Overflow), 1);
    checkVal("C.validHeld", 64'(ValidRx), 1);
    checkVal("C.dataHeld", 64'(DataRx), 64'(wd(2'd0, 3'd4, 32'h53525150)));
    FullRx = 1'b0;
    repeat (5) tick();
    VSync = 1'b0;
    repeat (4) tick();
    expectWord("C.p0", wd(2'd0, 3'd4, 32'h53525150));
    expectWord("C.p1", wd(2'd0, 3'd4, 32'h57565554));
    expectWord("C.p2", wd(2'd0, 3'd4, 32'h5b5a5958));
    expectWord("C.fe", wd(2'd3, 3'd0, 32'h00010001));
    checkVal("C.ovfSticky", 64'(Overflow), 1);
    // frame D: FS clears Overflow, then En drops mid-line
    VSync = 1'b1; tick(); tick(); tick();
    checkVal("D.ovfClr", 64'(Overflow), 0);
    HSync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      Data = 8'h60 + 8'(i);
      tick();
    end
    Data = 8'h63;
    En = 1'b0;
    tick();
    checkVal("D.enable", 64'(Enable), 0);
    checkVal("D.idle", 64'(dut.state), 64'(IDLE));
    HSync = 1'b0;
    Data = '0;
    repeat (4) tick();
    expectWord("D.fs", wd(2'd1, 3'd0, 32'd3));
    expectWord("D.p0", wd(2'd0, 3'd3, 32'h00626160));
    expectWord("D.fe", wd(2'd3, 3'd0, 32'h00010000));
    En = 1'b1;
    repeat (3) tick();
    doLine(4, 8'h90, 1'b0);
    repeat (3) tick();
    checkVal("D.noFs", 64'(rxQ.size()), 0);
    VSync = 1'b0;
    repeat (3) tick();
    // frame E: reset while words are waiting
    VSync = 1'b1;
    repeat (4) tick();
    expectWord("E.fs", wd(2'd1, 3'd0, 32'd4));
    FullRx = 1'b1;
    doLine(4, 8'h70, 1'b0);
    tick();
    checkVal("E.valid", 64'(ValidRx), 1);
    #3 Rst = 1'b1;
    #1;
    checkVal("E.rstValid", 64'(ValidRx), 0);
    checkVal("E.rstData", 64'(DataRx), 0);
    checkVal("E.rstFrameCnt", 64'(FrameCnt), 0);
    VSync = 1'b0;
    FullRx = 1'b0;
    tick();
    rxQ.delete();
    cycQ.delete();
    Rst = 1'b0;
    repeat (4) tick();
    // frame F: restart from FS(0); full word right at line end gives no empty flush
    VSync = 1'b1; tick(); tick();
    doLine(4, 8'h80, 1'b0);
    VSync = 1'b0;
    repeat (6) tick();
    expectWord("F.fs", wd(2'd1, 3'd0, 32'd0));
    expectWord("F.p0", wd(2'd0, 3'd4, 32'h83828180));
    expectWord("F.le", wd(2'd2, 3'd0, 32'd4));
    expectWord("F.fe", wd(2'd3, 3'd0, 32'd1));
    checkVal("F.frameCnt", 64'(FrameCnt), 1);
    doLine(4, 8'hA0, 1'b0);
    repeat (3) tick();
    checkVal("F.hsNoVs", 64'(rxQ.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
